// File: rtl/i2c_line_conditioner_if.sv
// ============================================================================
//  Module      : i2c_line_conditioner_if
//  Description : Signal bundle between the open-drain SDA/SCL pads, the I2C
//                master, and the line conditioner that sits between them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface i2c_line_conditioner_if;
   // pad side
   logic sda_pad_in;
   logic scl_pad_in;
   logic sda_oe;
   logic scl_oe;
   // master side
   logic master_sda_out;
   logic master_scl_out;
   logic sda_in;
   logic scl_in;
   // bus status
   logic start_det;
   logic stop_det;
   logic bus_busy;
   logic scl_stretching;
   logic scl_stuck;
   logic clear_flags;

   // The conditioner itself
   modport slave (
      input  sda_pad_in, scl_pad_in, master_sda_out, master_scl_out, clear_flags,
      output sda_oe, scl_oe, sda_in, scl_in, start_det, stop_det, bus_busy,
             scl_stretching, scl_stuck
   );

   // The I2C master / pad environment driving the conditioner
   modport master (
      output sda_pad_in, scl_pad_in, master_sda_out, master_scl_out, clear_flags,
      input  sda_oe, scl_oe, sda_in, scl_in, start_det, stop_det, bus_busy,
             scl_stretching, scl_stuck
   );
endinterface

`default_nettype wire

// File: rtl/i2c_line_conditioner.sv
// ============================================================================
//  Module      : i2c_line_conditioner
//  Description : Synchronizes and glitch-filters the SDA/SCL pads, turns the
//                master's line levels into open-drain pull-down enables,
//                detects START/STOP to track bus occupancy, and flags SCL
//                clock stretching and a stuck-low SCL after a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module i2c_line_conditioner #(
   parameter int FILTER_LEN     = 3,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   input  wire logic             sync_reset,
   i2c_line_conditioner_if.slave bus
);

   // Counter value at which a differing sample is accepted
   localparam logic [3:0]  c_FILTER_LAST  = 4'(FILTER_LEN - 1);
   // Counter value one cycle before the timeout is reached
   localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] c_TIMEOUT_MAX  = 16'(TIMEOUT_CYCLES);

   // Index 0 is SDA, index 1 is SCL throughout
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] r_filt;
   logic [3:0] r_fcnt [2];

   logic       r_sda_d;
   logic       r_scl_d;
   logic       r_start_det;
   logic       r_stop_det;
   logic       r_bus_busy;
   logic       r_sda_oe;
   logic       r_scl_oe;
   logic       r_scl_stretching;
   logic       r_scl_stuck;
   logic [15:0] r_to_cnt;

   logic       w_start;
   logic       w_stop;
   logic       w_stuck_set;

   // Two-flop synchronizer on both raw pad levels; idle bus level is 1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
      end else if (sync_reset) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
      end else begin
         r_sync1 <= {bus.scl_pad_in, bus.sda_pad_in};
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar i = 0; i < 2; i++) begin : g_filter
         // Accept a new level only after FILTER_LEN consecutive differing samples
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_filt[i] <= 1'b1;
               r_fcnt[i] <= 4'd0;
            end else if (sync_reset) begin
               r_filt[i] <= 1'b1;
               r_fcnt[i] <= 4'd0;
            end else if (r_sync2[i] == r_filt[i]) begin
               r_fcnt[i] <= 4'd0;
            end else if (r_fcnt[i] == c_FILTER_LAST) begin
               r_filt[i] <= ~r_filt[i];
               r_fcnt[i] <= 4'd0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + 4'd1;
            end
         end
      end
   endgenerate

   // SDA edge while SCL is high and steady; requiring scl_d == scl_in == 1
   // also rejects SDA and SCL changing on the same cycle
   assign w_start = r_sda_d & ~r_filt[0] & r_scl_d & r_filt[1];
   assign w_stop  = ~r_sda_d & r_filt[0] & r_scl_d & r_filt[1];

   // Registered drive enables, condition pulses and bus occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sda_d     <= 1'b1;
         r_scl_d     <= 1'b1;
         r_start_det <= 1'b0;
         r_stop_det  <= 1'b0;
         r_bus_busy  <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_scl_oe    <= 1'b0;
      end else if (sync_reset) begin
         r_sda_d     <= 1'b1;
         r_scl_d     <= 1'b1;
         r_start_det <= 1'b0;
         r_stop_det  <= 1'b0;
         r_bus_busy  <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_scl_oe    <= 1'b0;
      end else begin
         r_sda_d     <= r_filt[0];
         r_scl_d     <= r_filt[1];
         r_start_det <= w_start;
         r_stop_det  <= w_stop;
         r_sda_oe    <= ~bus.master_sda_out;
         r_scl_oe    <= ~bus.master_scl_out;
         if (w_start) begin
            r_bus_busy <= 1'b1;
         end else if (w_stop) begin
            r_bus_busy <= 1'b0;
         end
      end
   end

   // Sticky flag sets on the cycle the counter reaches the timeout value
   assign w_stuck_set = r_scl_stretching && (r_to_cnt == c_TIMEOUT_LAST);

   // Stretch detect, saturating low-time counter and sticky stuck flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_scl_stretching <= 1'b0;
         r_to_cnt         <= 16'd0;
         r_scl_stuck      <= 1'b0;
      end else if (sync_reset) begin
         r_scl_stretching <= 1'b0;
         r_to_cnt         <= 16'd0;
         r_scl_stuck      <= 1'b0;
      end else begin
         r_scl_stretching <= ~r_scl_oe & ~r_filt[1];
         if (!r_scl_stretching) begin
            r_to_cnt <= 16'd0;
         end else if (r_to_cnt != c_TIMEOUT_MAX) begin
            r_to_cnt <= r_to_cnt + 16'd1;
         end
         // A set on the same cycle as a clear request wins
         if (w_stuck_set) begin
            r_scl_stuck <= 1'b1;
         end else if (bus.clear_flags) begin
            r_scl_stuck <= 1'b0;
         end
      end
   end

   assign bus.sda_oe         = r_sda_oe;
   assign bus.scl_oe         = r_scl_oe;
   assign bus.sda_in         = r_filt[0];
   assign bus.scl_in         = r_filt[1];
   assign bus.start_det      = r_start_det;
   assign bus.stop_det       = r_stop_det;
   assign bus.bus_busy       = r_bus_busy;
   assign bus.scl_stretching = r_scl_stretching;
   assign bus.scl_stuck      = r_scl_stuck;

endmodule

`default_nettype wire

// File: doc/i2c_line_conditioner.md
# i2c_line_conditioner

Pad-side conditioning stage between the board-level open-drain SDA/SCL pins and the Wishbone I2C wrapper's `sda_in`/`scl_in`/`sda_out`/`scl_out` ports. It synchronizes and glitch-filters the raw pad inputs, converts the master's line levels into open-drain drive enables, and detects START and STOP conditions to track bus occupancy. It also detects SCL held low by a slave (clock stretching) and flags a stuck bus after a programmable timeout.

## Interface
- `FILTER_LEN`, 3: consecutive identical synchronized samples required before a filtered line changes; legal range 1..15.
- `TIMEOUT_CYCLES`, 50000: clk cycles of SCL held low while released before `scl_stuck` sets; legal range 1..65535.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `sync_reset`  in  1  synchronous clear of all state, same effect as reset, one cycle.
- `sda_pad_in`, `scl_pad_in`  in  1 each  raw asynchronous pad levels.
- `master_sda_out`, `master_scl_out`  in  1 each  line levels requested by the I2C master (1 = release, 0 = pull low).
- `sda_oe`, `scl_oe`  out  1 each  pad pull-down enables (1 = drive pad low).
- `sda_in`, `scl_in`  out  1 each  filtered line levels to the master.
- `start_det`, `stop_det`  out  1 each  single-cycle condition pulses.
- `bus_busy`  out  1  high between a detected START and the next STOP.
- `scl_stretching`  out  1  master releases SCL but filtered SCL is low.
- `scl_stuck`  out  1  sticky timeout flag.
- `clear_flags`  in  1  clears `scl_stuck` for one cycle.

## Operation
- Reset values: `sda_oe`=0, `scl_oe`=0, `sda_in`=1, `scl_in`=1, `start_det`=0, `stop_det`=0, `bus_busy`=0, `scl_stretching`=0, `scl_stuck`=0. Synchronizer flops reset to 1. Filter and timeout counters reset to 0.
- Synchronizer: two flops per pad input.
- Filter, one per line:
  - 4-bit counter compares the synchronized sample against the current filtered value.
  - Equal: counter resets to 0.
  - Differ and counter = FILTER_LEN−1: filtered value toggles and the counter resets to 0.
  - Differ otherwise: counter increments.
- Drive: `sda_oe` <= ~`master_sda_out` and `scl_oe` <= ~`master_scl_out`, both registered.
- Edge detect: registered copies of the filtered values, `sda_d` and `scl_d`.
  - START: `sda_d`=1, `sda_in`=0, `scl_d`=1, `scl_in`=1.
  - STOP: `sda_d`=0, `sda_in`=1, `scl_d`=1, `scl_in`=1.
  - Same-cycle SDA and SCL change: no detection.
  - `start_det` and `stop_det` are registered pulses, one cycle wide.
- `bus_busy`:
  - Sets on START and clears on STOP.
  - A repeated START keeps it at 1.
  - STOP while idle leaves it at 0.
- Stretch/timeout:
  - `scl_stretching` = `scl_oe`=0 AND `scl_in`=0, registered.
  - A 16-bit counter increments while `scl_stretching`=1, saturates at TIMEOUT_CYCLES, and clears when `scl_stretching`=0.
  - `scl_stuck` sets on the cycle the counter reaches TIMEOUT_CYCLES and stays set until `clear_flags` or reset.
  - `clear_flags` coinciding with the set condition: set wins.
- `sync_reset` has priority over all other updates except asynchronous reset.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately. Lines are released.

## Timing
- Pad to filtered output:
  - A pad level first captured at clk edge 0 (and held stable) appears on `sda_in`/`scl_in` after edge FILTER_LEN+1, i.e. edge 4 at the default.
  - Pulses shorter than FILTER_LEN sampled cycles are fully suppressed.
- Filtered edge to `start_det`/`stop_det`: +1 edge. `bus_busy` changes on the same edge as the pulse.
- `master_*_out` to `*_oe`: 1 edge.
- `scl_stretching`: 1 edge after its condition holds. `scl_stuck`: TIMEOUT_CYCLES edges after `scl_stretching` rises.

## Test plan
- Reset, then pads held at 1: all outputs hold their reset values. Drop `sda_pad_in` with SCL high → `sda_in`=0 after edge 4, `start_det` pulses once after edge 5, `bus_busy`=1.
- Glitch 2-cycle low on `scl_pad_in` (FILTER_LEN=3): `scl_in` stays 1 and no pulses. Glitch of 3 cycles → `scl_in` dips.
- Full transfer: START, 9 SCL pulses with SDA toggling only while SCL low, repeated START, STOP → exactly two `start_det`, one `stop_det`. `bus_busy` stays 1 throughout and returns to 0 after the STOP.
- SDA and SCL pads fall on the same cycle: no `start_det`.
- `master_scl_out`=1, `scl_pad_in` held 0, TIMEOUT_CYCLES=20:
  - `scl_stretching`=1.
  - `scl_stuck` sets exactly 20 edges later.
  - Release pad → `scl_stuck` stays 1 until `clear_flags`.
- `sync_reset` asserted with `bus_busy`=1 and `scl_stuck`=1 → both 0 next edge. `master_sda_out`=0 → `sda_oe`=1 one edge later.
